// File: rtl/ddr3_app_pattern_tester.sv
// ddr3_app_pattern_tester: write/read-back pattern generator and checker for the
// MIG 7-series app (UI) interface, running in the ui_clk domain.
// Optional build macro: LOOP_EN -- passing passes restart automatically with seed+1
// and o_done pulses for one cycle per pass; a failing pass stops in DONE.
module ddr3_app_pattern_tester #(
  parameter int unsigned             ADDR_WIDTH = 28,
  parameter int unsigned             DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter int unsigned             NUM_WORDS  = 1024,
  parameter int unsigned             ADDR_STEP  = 8,
  parameter logic [31:0]             SEED       = 32'hA5A5_0000,
  parameter int unsigned             TIMEOUT    = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_calib_done,
  output logic [ADDR_WIDTH-1:0]     o_app_addr,
  output logic [2:0]                o_app_cmd,
  output logic                      o_app_en,
  output logic [DATA_WIDTH-1:0]     o_app_wdf_data,
  output logic                      o_app_wdf_wren,
  output logic                      o_app_wdf_end,
  output logic [DATA_WIDTH/8-1:0]   o_app_wdf_mask,
  input  logic                      i_app_rdy,
  input  logic                      i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]     i_app_rd_data,
  input  logic                      i_app_rd_data_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      o_timeout,
  output logic [15:0]               o_err_count,
  output logic [ADDR_WIDTH-1:0]     o_first_err_addr
);

  localparam int unsigned LANES = DATA_WIDTH / 32;
  localparam int unsigned CW    = $clog2(NUM_WORDS + 1);
  localparam int unsigned WW    = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]         LAST_WORD = CW'(NUM_WORDS - 1);
  localparam logic [WW-1:0]         WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [2:0]            CMD_WR    = 3'b000;
  localparam logic [2:0]            CMD_RD    = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CAL,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t              state;
  logic [31:0]         seed;
  logic [CW-1:0]       wr_cnt;
  logic [CW-1:0]       rd_cnt;
  logic [CW-1:0]       chk_cnt;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                cmd_taken;
  logic                dat_taken;
  logic [WW-1:0]       wd_cnt;

  logic                cmd_acc;
  logic                dat_acc;
  logic                rd_valid;
  logic                mismatch;
  logic                progress;
  logic                wd_expire;
  logic                pair_done;
  logic [DATA_WIDTH-1:0] exp_data;

  // Address-derived pattern: lane i = (zero-extended addr ^ seed) + i
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [31:0] s);
    logic [31:0] b;
    pattern = '0;
    b = 32'(a) ^ s;
    for (int i = 0; i < int'(LANES); i++) begin
      pattern[32*i +: 32] = b + 32'(i);
    end
  endfunction

  assign o_app_wdf_end  = o_app_wdf_wren;
  assign o_app_wdf_mask = '0;

  // Handshake, check and watchdog qualifiers for the current cycle
  always_comb begin
    cmd_acc   = o_app_en & i_app_rdy;
    dat_acc   = o_app_wdf_wren & i_app_wdf_rdy;
    rd_valid  = i_app_rd_data_valid & (state == S_READ);
    exp_data  = pattern(chk_addr, seed);
    mismatch  = rd_valid & (i_app_rd_data != exp_data);
    pair_done = (cmd_taken | cmd_acc) & (dat_taken | dat_acc);
    progress  = 1'b0;
    wd_expire = 1'b0;
    if (state == S_WRITE) begin
      progress = cmd_acc | dat_acc;
    end else if (state == S_READ) begin
      progress = cmd_acc | rd_valid;
    end
    if (state == S_WRITE || state == S_READ) begin
      wd_expire = !i_calib_done || (!progress && wd_cnt == WD_LAST);
    end
  end

  // Test sequencer: write pass, read-back pass with independent check pointer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      seed             <= SEED;
      wr_cnt           <= '0;
      rd_cnt           <= '0;
      chk_cnt          <= '0;
      chk_addr         <= '0;
      cmd_taken        <= 1'b0;
      dat_taken        <= 1'b0;
      wd_cnt           <= '0;
      o_app_addr       <= '0;
      o_app_cmd        <= CMD_WR;
      o_app_en         <= 1'b0;
      o_app_wdf_data   <= '0;
      o_app_wdf_wren   <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_error          <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state  <= S_WAIT_CAL;
            o_busy <= 1'b1;
          end
        end

        S_WAIT_CAL: begin
          if (i_calib_done) begin
            state          <= S_WRITE;
            o_app_addr     <= BASE_ADDR;
            o_app_cmd      <= CMD_WR;
            o_app_en       <= 1'b1;
            o_app_wdf_wren <= 1'b1;
            o_app_wdf_data <= pattern(BASE_ADDR, seed);
            wr_cnt         <= '0;
            cmd_taken      <= 1'b0;
            dat_taken      <= 1'b0;
            wd_cnt         <= '0;
          end
        end

        S_WRITE: begin
          if (wd_expire) begin
            state          <= S_DONE;
            o_timeout      <= 1'b1;
            o_error        <= 1'b1;
            o_done         <= 1'b1;
            o_busy         <= 1'b0;
            o_app_en       <= 1'b0;
            o_app_wdf_wren <= 1'b0;
          end else begin
            wd_cnt <= progress ? '0 : wd_cnt + WW'(1);
            if (pair_done) begin
              cmd_taken <= 1'b0;
              dat_taken <= 1'b0;
              if (wr_cnt == LAST_WORD) begin
                state          <= S_READ;
                o_app_cmd      <= CMD_RD;
                o_app_addr     <= BASE_ADDR;
                o_app_en       <= 1'b1;
                o_app_wdf_wren <= 1'b0;
                rd_cnt         <= '0;
                chk_cnt        <= '0;
                chk_addr       <= BASE_ADDR;
              end else begin
                o_app_addr     <= o_app_addr + STEP;
                o_app_wdf_data <= pattern(o_app_addr + STEP, seed);
                o_app_en       <= 1'b1;
                o_app_wdf_wren <= 1'b1;
                wr_cnt         <= wr_cnt + CW'(1);
              end
            end else begin
              // Command and data each drop once accepted and wait for the other
              if (cmd_acc) begin
                o_app_en  <= 1'b0;
                cmd_taken <= 1'b1;
              end
              if (dat_acc) begin
                o_app_wdf_wren <= 1'b0;
                dat_taken      <= 1'b1;
              end
            end
          end
        end

        S_READ: begin
          if (wd_expire) begin
            state     <= S_DONE;
            o_timeout <= 1'b1;
            o_error   <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_app_en  <= 1'b0;
          end else begin
            wd_cnt <= progress ? '0 : wd_cnt + WW'(1);
            if (cmd_acc) begin
              if (rd_cnt == LAST_WORD) begin
                o_app_en <= 1'b0;
              end else begin
                o_app_addr <= o_app_addr + STEP;
                rd_cnt     <= rd_cnt + CW'(1);
              end
            end
            if (rd_valid) begin
              if (mismatch) begin
                o_error <= 1'b1;
                if (o_err_count == '0) begin
                  o_first_err_addr <= chk_addr;
                end
                if (o_err_count != 16'hFFFF) begin
                  o_err_count <= o_err_count + 16'd1;
                end
              end
              chk_addr <= chk_addr + STEP;
              chk_cnt  <= chk_cnt + CW'(1);
              if (chk_cnt == LAST_WORD) begin
                state    <= S_DONE;
                o_done   <= 1'b1;
                o_busy   <= 1'b0;
                o_app_en <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
`ifdef LOOP_EN
          if (!o_error) begin
            // Passing pass: bump the seed and go straight back to writing
            state          <= S_WRITE;
            seed           <= seed + 32'd1;
            o_done         <= 1'b0;
            o_busy         <= 1'b1;
            o_app_addr     <= BASE_ADDR;
            o_app_cmd      <= CMD_WR;
            o_app_en       <= 1'b1;
            o_app_wdf_wren <= 1'b1;
            o_app_wdf_data <= pattern(BASE_ADDR, seed + 32'd1);
            wr_cnt         <= '0;
            cmd_taken      <= 1'b0;
            dat_taken      <= 1'b0;
            wd_cnt         <= '0;
          end else if (i_start) begin
            state       <= S_WAIT_CAL;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_count <= '0;
          end
`else
          if (i_start) begin
            state       <= S_WAIT_CAL;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_count <= '0;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
